prco_fetch: RTL and testbench
=============================

PRCO_FETCH -- requirements
Module: prco_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the program counter value loaded on reset.
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have port i_en, input, 1 bit, fetch enable; 0 stops new fetches after the current one.
REQ-005 The block SHALL have port q_imem_re, output, 1 bit, instruction memory read strobe.
REQ-006 The block SHALL have port q_imem_addr, output, 16 bits, instruction word address.
REQ-007 The block SHALL have port i_imem_data, input, 16 bits, memory read data, valid the cycle after q_imem_re.
REQ-008 The block SHALL have port q_instr, output, 16 bits, instruction presented to the decoder i_instr.
REQ-009 The block SHALL have port q_ce, output, 1 bit, one-cycle issue pulse to the decoder i_ce.
REQ-010 The block SHALL have port q_pc, output, 16 bits, address of the instruction currently on q_instr.
REQ-011 The block SHALL have port i_fetch, input, 1 bit, next-instruction request pulse from the decoder q_fetch.
REQ-012 The block SHALL have port i_jmp, input, 1 bit, PC redirect request.
REQ-013 The block SHALL have port i_jmp_addr, input, 16 bits, redirect target.
REQ-014 The block SHALL have port q_icount, output, 16 bits, count of issued instructions.

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, MEM, ISSUE and WAIT, with every output registered or decoded from state only.
REQ-016 The FSM SHALL transition IDLE->FETCH when i_en=1; otherwise it stays in IDLE.
REQ-017 In FETCH, q_imem_re SHALL be 1 and q_imem_addr SHALL equal pc; FETCH->MEM unconditionally.
REQ-018 In MEM, the block SHALL latch i_imem_data into q_instr and pc into q_pc, set pc<=pc+1 with 16-bit wrap (16'hFFFF->16'h0000), and transition MEM->ISSUE.
REQ-019 In ISSUE, q_ce SHALL be 1 for exactly one cycle and q_icount SHALL increment mod 2^16; ISSUE->WAIT.
REQ-020 In WAIT, q_instr and q_pc SHALL hold stable; on i_fetch=1, WAIT->FETCH if i_en=1, else WAIT->IDLE.
REQ-021 q_imem_re SHALL be 0 in all states except FETCH, and q_ce SHALL be 0 in all states except ISSUE.
REQ-022 Issue latency SHALL be 3 cycles from FETCH entry to the q_ce high cycle (FETCH, MEM, ISSUE).
REQ-023 When i_jmp=1 in IDLE, the block SHALL set pc<=i_jmp_addr and remain in IDLE.
REQ-024 When i_jmp=1 in FETCH or MEM, the block SHALL set pc<=i_jmp_addr, leave q_instr/q_pc/q_icount unchanged (in-flight data discarded), and go to FETCH.
REQ-025 When i_jmp=1 in ISSUE or WAIT, the q_ce pulse (if in ISSUE) SHALL still complete, pc SHALL become i_jmp_addr, and the next state SHALL be FETCH without waiting for i_fetch.
REQ-026 When i_jmp and i_fetch are high in the same cycle, the jump SHALL win and exactly one fetch occurs, at i_jmp_addr.
REQ-027 An i_fetch pulse in any state other than WAIT SHALL be ignored.
REQ-028 Deasserting i_en mid-operation SHALL NOT abort a fetch already started; the instruction SHALL issue and the FSM SHALL park in WAIT, then IDLE on i_fetch.

Reset
REQ-029 When i_rst_n=0 at a rising edge, the block SHALL set state=IDLE, pc=RESET_PC, q_instr=16'h0000, q_pc=RESET_PC, q_ce=0, q_imem_re=0, q_imem_addr=RESET_PC and q_icount=0, with reset overriding i_jmp and i_fetch.
REQ-030 Reset asserted mid-fetch SHALL discard the in-flight read; no q_ce SHALL follow it.

Verification
REQ-031 Reset then i_en=1 with mem[0]=16'h0A05 SHALL produce q_imem_re at addr 0 one cycle, then q_ce=1 two cycles later with q_instr=16'h0A05, q_pc=0 and q_icount=1.
REQ-032 Holding in WAIT for 10 cycles without i_fetch SHALL keep q_ce=0 and q_instr stable, and the next i_fetch SHALL read addr 1.
REQ-033 With pc=16'hFFFF, an issue from addr FFFF followed by i_fetch SHALL make the next read addr 16'h0000.
REQ-034 i_jmp=1 with addr 16'h0040 during MEM SHALL produce no q_ce for the squashed word, and the next issue SHALL have q_pc=16'h0040.
REQ-035 i_jmp (addr 16'h0010) and i_fetch high together in WAIT SHALL cause a single read at 16'h0010 and one q_ce.
REQ-036 i_rst_n=0 during MEM SHALL leave all outputs at reset values the next cycle, with no q_ce pulse.

Source files
------------

// File: rtl/prco_fetch.sv
// ============================================================================
// prco_fetch : instruction fetch unit. It issues one instruction per decoder request.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module prco_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        q_imem_re,
  output logic [15:0] q_imem_addr,
  input  logic [15:0] i_imem_data,
  output logic [15:0] q_instr,
  output logic        q_ce,
  output logic [15:0] q_pc,
  input  logic        i_fetch,
  input  logic        i_jmp,
  input  logic [15:0] i_jmp_addr,
  output logic [15:0] q_icount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_ipc;
  logic [15:0] r_icount;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 16'h0000;
      r_ipc    <= RESET_PC;
      r_icount <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_jmp)     r_pc    <= i_jmp_addr;
          else if (i_en) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_jmp) r_pc <= i_jmp_addr;
          r_state <= i_jmp ? S_FETCH : S_MEM;
        end
        S_MEM: begin
          if (i_jmp) begin
            r_pc    <= i_jmp_addr;
            r_state <= S_FETCH;
          end else begin
            // The count is bumped here so it already shows the new total while q_ce is high.
            r_instr  <= i_imem_data;
            r_ipc    <= r_pc;
            r_pc     <= r_pc + 16'd1;
            r_icount <= r_icount + 16'd1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_jmp) r_pc <= i_jmp_addr;
          r_state <= i_jmp ? S_FETCH : S_WAIT;
        end
        S_WAIT: begin
          if (i_jmp) begin
            r_pc    <= i_jmp_addr;
            r_state <= S_FETCH;
          end else if (i_fetch) begin
            r_state <= i_en ? S_FETCH : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q_imem_re   = (r_state == S_FETCH);
  assign q_ce        = (r_state == S_ISSUE);
  assign q_imem_addr = r_pc;
  assign q_instr     = r_instr;
  assign q_pc        = r_ipc;
  assign q_icount    = r_icount;

endmodule

`default_nettype wire

// File: tb/tb_prco_fetch.sv
// ============================================================================
// tb_prco_fetch : scoreboard bench for prco_fetch (reads and issues are checked against queues).
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prco_fetch;

  logic        clk = 1'b0;
  logic        rst_n, en, fetch, jmp;
  logic [15:0] jmp_addr, imem_data;
  logic        imem_re, ce;
  logic [15:0] imem_addr, instr, pc, icount;

  prco_fetch #(.RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .q_imem_re(imem_re), .q_imem_addr(imem_addr), .i_imem_data(imem_data),
    .q_instr(instr), .q_ce(ce), .q_pc(pc),
    .i_fetch(fetch), .i_jmp(jmp), .i_jmp_addr(jmp_addr), .q_icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] instr; logic [15:0] pc; logic [15:0] icount; } issue_t;
  typedef struct { logic jmp; logic [15:0] jaddr; logic fetch; logic [15:0] exp_addr; } vec_t;

  logic [15:0] rd_q[$];
  issue_t      iss_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cyc = 0;
  logic [15:0] exp_icount = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0000) ? 16'h0A05 : ((a ^ 16'hC3C3) + 16'h0101);
  endfunction

  // Data is only valid in the cycle after a read strobe; otherwise a poison value is driven.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    imem_data <= imem_re ? mem_word(imem_addr) : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_re === 1'b1) begin
      rd_cyc = cyc;
      if (rd_q.size() == 0) chk("unexpected_read", imem_addr, 16'hXXXX);
      else chk("read_addr", imem_addr, rd_q.pop_front());
    end
    if (ce === 1'b1) begin
      if (iss_q.size() == 0) chk("spurious_ce", instr, 16'hXXXX);
      else begin
        issue_t e;
        e = iss_q.pop_front();
        chk("issue_instr", instr, e.instr);
        chk("issue_pc", pc, e.pc);
        chk("issue_icount", icount, e.icount);
        chk("issue_latency", 16'(cyc - rd_cyc), 16'd2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [15:0] a);
    issue_t e;
    exp_icount = exp_icount + 16'd1;
    e.instr  = mem_word(a);
    e.pc     = a;
    e.icount = exp_icount;
    rd_q.push_back(a);
    iss_q.push_back(e);
  endtask

  // Returns one cycle into WAIT after the issue pulse.
  task automatic wait_ce();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ce === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("ce_timeout", 16'd0, 16'd1);
    tick();
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_re"},     {15'd0, imem_re}, 16'd0);
    chk({tag, "_ce"},     {15'd0, ce},      16'd0);
    chk({tag, "_addr"},   imem_addr,        16'h0000);
    chk({tag, "_instr"},  instr,            16'h0000);
    chk({tag, "_pc"},     pc,               16'h0000);
    chk({tag, "_icount"}, icount,           16'h0000);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 1'b1, 16'h0002};
    tbl[1] = '{1'b1, 16'h0010, 1'b1, 16'h0010};
    tbl[2] = '{1'b1, 16'h0100, 1'b0, 16'h0100};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 16'h0101};
    tbl[4] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 16'h0001};

    rst_n = 1'b0; en = 1'b0; fetch = 1'b0; jmp = 1'b0; jmp_addr = 16'h0000;
    repeat (3) tick();
    chk_reset("reset");

    // First fetch out of reset.
    tick();
    expect_issue(16'h0000);
    rst_n = 1'b1; en = 1'b1;
    wait_ce();

    // Idle in WAIT: nothing may be read or issued, and the outputs must hold.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_instr", instr, 16'h0A05);
      chk("hold_pc", pc, 16'h0000);
    end
    tick();
    expect_issue(16'h0001);
    fetch = 1'b1; tick(); fetch = 1'b0;
    wait_ce();

    foreach (tbl[k]) begin
      expect_issue(tbl[k].exp_addr);
      jmp = tbl[k].jmp; jmp_addr = tbl[k].jaddr; fetch = tbl[k].fetch;
      tick();
      jmp = 1'b0; fetch = 1'b0;
      wait_ce();
    end

    // Jump while the read at 2 is in MEM: that word is squashed.
    rd_q.push_back(16'h0002);
    fetch = 1'b1; tick(); fetch = 1'b0;
    tick();
    expect_issue(16'h0040);
    jmp = 1'b1; jmp_addr = 16'h0040; tick(); jmp = 1'b0;
    wait_ce();

    // Drop enable mid-fetch: the issue completes, then the next request parks in IDLE.
    expect_issue(16'h0041);
    fetch = 1'b1; tick(); fetch = 1'b0; en = 1'b0;
    wait_ce();
    fetch = 1'b1; tick(); fetch = 1'b0;
    repeat (5) tick();
    jmp = 1'b1; jmp_addr = 16'h0200; tick(); jmp = 1'b0;
    repeat (3) tick();
    expect_issue(16'h0200);
    en = 1'b1;
    wait_ce();

    // Reset while the read at 0x201 is in MEM.
    rd_q.push_back(16'h0201);
    fetch = 1'b1; tick(); fetch = 1'b0;
    tick();
    rst_n = 1'b0; en = 1'b0;
    tick();
    chk_reset("mem_reset");
    exp_icount = 16'h0000;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    chk("reads_left", 16'(rd_q.size()), 16'd0);
    chk("issues_left", 16'(iss_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
